vc_input_buffer: RTL and testbench
==================================

Name: vc_input_buffer

Overview:
- Per-input-port virtual-channel buffer bank for the VC router: the parametrised successor to the single-flit-per-VC storage now in router_top.
- Holds BUF_DEPTH flits per VC as circular FIFOs and tracks the per-VC packet state (IDLE/ROUTING/VC_ALLOC/ACTIVE) from head to tail.
- Returns one credit per flit drained to the upstream router.
- Sits between link input and the RC/VA/SA stages; one instance per router port.

Parameters:
- FLIT_WIDTH, `FLIT_DATA_WIDTH: flit width. Bits [FLIT_WIDTH-1 -: 2] are the flit type: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL.
- NUM_VC, 4: virtual channels per port.
- BUF_DEPTH, 4: flits per VC FIFO. Power of two, ≥2.
- VC_BITS, $clog2(NUM_VC): VC index width.
- CNT_BITS, $clog2(BUF_DEPTH+1): occupancy counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- in_flit  in  FLIT_WIDTH  incoming flit
- in_valid  in  1  in_flit/in_vc valid this cycle
- in_vc  in  VC_BITS  target VC of incoming flit
- rc_done  in  NUM_VC  route computed for the head flit of VC i (pulse)
- va_grant  in  NUM_VC  output VC granted to VC i (pulse)
- rd_en  in  1  switch-allocation winner read request
- rd_vc  in  VC_BITS  VC to read
- out_flit  out  FLIT_WIDTH  flit read, registered
- out_valid  out  1  out_flit valid
- head_flit  out  NUM_VC*FLIT_WIDTH  front flit of each VC (combinational peek, for RC)
- vc_empty  out  NUM_VC  FIFO i empty
- vc_state  out  NUM_VC*2  per-VC state: 00 IDLE, 01 ROUTING, 10 VC_ALLOC, 11 ACTIVE
- credit_valid  out  1  one credit returned upstream
- credit_vc  out  VC_BITS  VC of the returned credit
- overflow_err  out  1  sticky: a write hit a full VC

Behaviour:
Reset (reset=0, asynchronous; released synchronously to clk by the top):
- All pointers and counts clear; vc_empty all 1.
- vc_state all IDLE.
- out_flit 0, out_valid 0, credit_valid 0, credit_vc 0, overflow_err 0.

Write:
- in_valid=1 with count[in_vc] < BUF_DEPTH stores the flit at wr_ptr[in_vc], which increments modulo BUF_DEPTH. Visible in head_flit / vc_empty next cycle.
- Write to a full VC: flit dropped, pointers unchanged, overflow_err set until reset.

Read:
- Legal only when rd_en=1, vc_state[rd_vc]=ACTIVE and count[rd_vc]>0.
- Legal read: out_flit ← mem[rd_vc][rd_ptr], out_valid=1 next cycle (1-cycle latency); rd_ptr increments modulo BUF_DEPTH; credit_valid=1, credit_vc=rd_vc next cycle.
- Illegal read: ignored; out_valid=0 and credit_valid=0 next cycle.
- out_valid and credit_valid are single-cycle pulses.

Same VC read and write in one cycle:
- Both occur; count unchanged.
- Write to a full VC still drops even if the same-cycle read frees a slot (full check uses the pre-read count).

Per-VC FSM, evaluated each cycle:
- IDLE → ROUTING when the FIFO is non-empty and the front flit type is HEAD or HEAD_TAIL.
- A non-head flit at the front in IDLE stays IDLE and is not readable.
- ROUTING → VC_ALLOC on rc_done[i].
- VC_ALLOC → ACTIVE on va_grant[i].
- ACTIVE → IDLE on a legal read of a TAIL or HEAD_TAIL flit. If the next head is already buffered, ROUTING follows one cycle later via IDLE.
- rc_done/va_grant pulses arriving in any other state are ignored.

Wrap-around:
- Pointers wrap at BUF_DEPTH; count distinguishes full from empty.
- Reset mid-packet aborts the packet: buffer contents are discarded and the state returns to IDLE.

Decomposition:
- vr_pkg, shared across the codebase:
  - flit_type_e enum: HEAD, BODY, TAIL, HEAD_TAIL.
  - vc_state_e enum: IDLE, ROUTING, VC_ALLOC, ACTIVE.
  - FLIT_TYPE_MSB/LSB localparams.
  - Helper function is_head(flit), is_tail(flit).
- One sub-module, vc_fifo:
  - Single-VC circular FIFO with wr_en, rd_en, data, full, empty, count, front.
  - Instantiated NUM_VC times by generate.
- The per-VC FSM and credit/output registers stay in vc_input_buffer.

Test Plan:
- Reset: drive reset=0 mid-traffic → all outputs at reset values within the same cycle; vc_state=0, vc_empty=4'b1111.
- Single packet on VC2: write HEAD, BODY, TAIL; pulse rc_done[2], then va_grant[2]; 3 reads → out_valid pulses carry the 3 flits in order, credit_valid x3 with credit_vc=2, vc_state[2]: 00→01→10→11→00.
- Full/overflow: write 5 BODY-after-HEAD flits to VC0 with BUF_DEPTH=4 → 5th dropped, overflow_err=1, count stays 4.
- Simultaneous read+write on ACTIVE VC1 holding 2 flits → count remains 2; pointers wrap after 6 such cycles; FIFO order preserved.
- Illegal reads: rd_en on an empty VC, and on a VC in ROUTING → out_valid=0, credit_valid=0, no state change.
- Back-to-back HEAD_TAIL packets on VC3 → each goes ROUTING→VC_ALLOC→ACTIVE→IDLE independently; one credit per flit; other VCs unaffected.

Source files
------------

// File: rtl/vr_pkg.sv
// Shared VC-router types: flit and per-VC packet state encodings plus flit-type helpers.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package vr_pkg;

    typedef enum logic [1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ROUTING  = 2'b01,
        VC_ALLOC = 2'b10,
        ACTIVE   = 2'b11
    } vc_state_e;

    localparam int FLIT_TYPE_MSB = `FLIT_DATA_WIDTH - 1;
    localparam int FLIT_TYPE_LSB = `FLIT_DATA_WIDTH - 2;

    // Both helpers take the 2-bit type field sliced from the top of a flit.
    function automatic logic is_head(input logic [1:0] ftype);
        return (ftype == HEAD) || (ftype == HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] ftype);
        return (ftype == TAIL) || (ftype == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/vc_input_buffer_if.sv
// Link-side, allocator-side and credit signals of one router input port's VC buffer.
interface vc_input_buffer_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int NUM_VC     = 4,
    parameter int VC_BITS    = $clog2(NUM_VC)
);
    logic [FLIT_WIDTH-1:0]        in_flit;
    logic                         in_valid;
    logic [VC_BITS-1:0]           in_vc;
    logic [NUM_VC-1:0]            rc_done;
    logic [NUM_VC-1:0]            va_grant;
    logic                         rd_en;
    logic [VC_BITS-1:0]           rd_vc;
    logic [FLIT_WIDTH-1:0]        out_flit;
    logic                         out_valid;
    logic [NUM_VC*FLIT_WIDTH-1:0] head_flit;
    logic [NUM_VC-1:0]            vc_empty;
    logic [NUM_VC*2-1:0]          vc_state;
    logic                         credit_valid;
    logic [VC_BITS-1:0]           credit_vc;
    logic                         overflow_err;

    modport master (
        output in_flit, in_valid, in_vc, rc_done, va_grant, rd_en, rd_vc,
        input  out_flit, out_valid, head_flit, vc_empty, vc_state,
               credit_valid, credit_vc, overflow_err
    );

    modport slave (
        input  in_flit, in_valid, in_vc, rc_done, va_grant, rd_en, rd_vc,
        output out_flit, out_valid, head_flit, vc_empty, vc_state,
               credit_valid, credit_vc, overflow_err
    );
endinterface

// File: rtl/vc_fifo.sv
// Single-VC circular flit FIFO; a write into a full FIFO is dropped, judged on the pre-read count.
module vc_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [WIDTH-1:0]    data,
    output logic                full,
    output logic                empty,
    output logic [CNT_BITS-1:0] count,
    output logic [WIDTH-1:0]    front
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                wr_ok;
    logic                rd_ok;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign front = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= data;
    end

    // Pointers wrap naturally since DEPTH is a power of two; count separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vc_input_buffer.sv
// Per-port VC buffer bank: one FIFO per VC, per-VC packet FSM, registered read port and credit return.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module vc_input_buffer
    import vr_pkg::*;
#(
    parameter int FLIT_WIDTH = `FLIT_DATA_WIDTH,
    parameter int NUM_VC     = 4,
    parameter int BUF_DEPTH  = 4,
    parameter int VC_BITS    = $clog2(NUM_VC),
    parameter int CNT_BITS   = $clog2(BUF_DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    vc_input_buffer_if.slave bus
);
    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic [NUM_VC-1:0]     wr_en;
    logic [NUM_VC-1:0]     rd_fire;
    logic [NUM_VC-1:0]     full;
    logic [NUM_VC-1:0]     empty;
    logic [CNT_BITS-1:0]   count [NUM_VC];
    logic [FLIT_WIDTH-1:0] front [NUM_VC];
    vc_state_e             state_q [NUM_VC];
    vc_state_e             state_d [NUM_VC];
    logic                  rd_legal;
    logic [FLIT_WIDTH-1:0] out_flit_q;
    logic                  out_valid_q;
    logic                  credit_valid_q;
    logic [VC_BITS-1:0]    credit_vc_q;
    logic                  overflow_q;

    // Assertion is immediate; release is retimed to clk so no flop leaves reset mid-edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign rd_legal = bus.rd_en && (state_q[bus.rd_vc] == ACTIVE) && (count[bus.rd_vc] != '0);

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        assign wr_en[i]   = bus.in_valid && (bus.in_vc == VC_BITS'(i));
        assign rd_fire[i] = rd_legal && (bus.rd_vc == VC_BITS'(i));

        vc_fifo #(
            .WIDTH    (FLIT_WIDTH),
            .DEPTH    (BUF_DEPTH),
            .CNT_BITS (CNT_BITS)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .wr_en (wr_en[i]),
            .rd_en (rd_fire[i]),
            .data  (bus.in_flit),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i]),
            .front (front[i])
        );

        assign bus.head_flit[i*FLIT_WIDTH +: FLIT_WIDTH] = front[i];
        assign bus.vc_state[2*i +: 2]                    = state_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) state_q[i] <= IDLE;
        end else begin
            for (int i = 0; i < NUM_VC; i++) state_q[i] <= state_d[i];
        end
    end

    // A non-head flit stranded at the front of an IDLE VC keeps it IDLE and unreadable.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:     if (!empty[i] && is_head(front[i][FLIT_WIDTH-1 -: 2])) state_d[i] = ROUTING;
                ROUTING:  if (bus.rc_done[i])  state_d[i] = VC_ALLOC;
                VC_ALLOC: if (bus.va_grant[i]) state_d[i] = ACTIVE;
                ACTIVE:   if (rd_fire[i] && is_tail(front[i][FLIT_WIDTH-1 -: 2])) state_d[i] = IDLE;
                default:  state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flit_q     <= '0;
            out_valid_q    <= 1'b0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            out_valid_q    <= rd_legal;
            credit_valid_q <= rd_legal;
            if (rd_legal) begin
                out_flit_q  <= front[bus.rd_vc];
                credit_vc_q <= bus.rd_vc;
            end
            if (bus.in_valid && full[bus.in_vc]) overflow_q <= 1'b1;
        end
    end

    assign bus.out_flit     = out_flit_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.vc_empty     = empty;
    assign bus.credit_valid = credit_valid_q;
    assign bus.credit_vc    = credit_vc_q;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: directed scenarios plus random traffic against a queue-level packet model.
module tb_vc_input_buffer;
    localparam int FW    = 32;
    localparam int NV    = 4;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vc_input_buffer_if #(.FLIT_WIDTH(FW), .NUM_VC(NV), .VC_BITS(2)) bus ();

    vc_input_buffer #(
        .FLIT_WIDTH (FW),
        .NUM_VC     (NV),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: one queue per VC, packet phase per VC (0 idle,1 routing,2 vc-alloc,3 active)
    logic [FW-1:0] mq [NV][$];
    int            mstate [NV];
    bit            movf;
    bit            exp_ov;
    bit            exp_cv;
    logic [FW-1:0] exp_of;
    int            exp_cvc;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
        return {t, p};
    endfunction

    function automatic bit starts_packet(input logic [FW-1:0] f);
        return (f[FW-1 -: 2] == 2'b00) || (f[FW-1 -: 2] == 2'b11);
    endfunction

    function automatic bit ends_packet(input logic [FW-1:0] f);
        return (f[FW-1 -: 2] == 2'b10) || (f[FW-1 -: 2] == 2'b11);
    endfunction

    function automatic logic [2*NV-1:0] exp_states();
        logic [2*NV-1:0] r;
        for (int v = 0; v < NV; v++) r[2*v +: 2] = 2'(mstate[v]);
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_empty();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (mq[v].size() == 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            mstate[v] = 0;
        end
        movf    = 1'b0;
        exp_ov  = 1'b0;
        exp_cv  = 1'b0;
        exp_of  = '0;
        exp_cvc = 0;
    endtask

    task automatic model_step(input bit iv, input int ivc, input logic [FW-1:0] f,
                              input logic [NV-1:0] rc, input logic [NV-1:0] va,
                              input bit re, input int rvc);
        bit            legal;
        bit            drop;
        logic [FW-1:0] popped;
        int            ns [NV];
        legal  = re && (mstate[rvc] == 3) && (mq[rvc].size() > 0);
        popped = '0;
        for (int v = 0; v < NV; v++) begin
            ns[v] = mstate[v];
            if (mstate[v] == 0 && mq[v].size() > 0 && starts_packet(mq[v][0])) ns[v] = 1;
            else if (mstate[v] == 1 && rc[v]) ns[v] = 2;
            else if (mstate[v] == 2 && va[v]) ns[v] = 3;
            else if (mstate[v] == 3 && legal && rvc == v && ends_packet(mq[v][0])) ns[v] = 0;
        end
        drop = iv && (mq[ivc].size() == DEPTH);
        if (legal) popped = mq[rvc].pop_front();
        if (iv) begin
            if (drop) movf = 1'b1;
            else      mq[ivc].push_back(f);
        end
        for (int v = 0; v < NV; v++) mstate[v] = ns[v];
        exp_ov = legal;
        exp_cv = legal;
        if (legal) begin
            exp_of  = popped;
            exp_cvc = rvc;
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_vc    = '0;
        bus.in_flit  = '0;
        bus.rc_done  = '0;
        bus.va_grant = '0;
        bus.rd_en    = 1'b0;
        bus.rd_vc    = '0;
    endtask

    // One clock: drive at edge+1, let the DUT sample, advance the model, return at next edge+1.
    task automatic cyc(input bit iv, input int ivc, input logic [FW-1:0] f,
                       input logic [NV-1:0] rc, input logic [NV-1:0] va,
                       input bit re, input int rvc);
        bus.in_valid = iv;
        bus.in_vc    = 2'(ivc);
        bus.in_flit  = f;
        bus.rc_done  = rc;
        bus.va_grant = va;
        bus.rd_en    = re;
        bus.rd_vc    = 2'(rvc);
        @(posedge clk);
        model_step(iv, ivc, f, rc, va, re, rvc);
        #1;
        idle_inputs();
    endtask

    task automatic wr(input int vc, input logic [FW-1:0] f);
        cyc(1'b1, vc, f, '0, '0, 1'b0, 0);
    endtask

    task automatic rd(input int vc);
        cyc(1'b0, 0, '0, '0, '0, 1'b1, vc);
    endtask

    task automatic pulse_rc(input int vc);
        cyc(1'b0, 0, '0, NV'(1 << vc), '0, 1'b0, 0);
    endtask

    task automatic pulse_va(input int vc);
        cyc(1'b0, 0, '0, '0, NV'(1 << vc), 1'b0, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        release_reset();
    endtask

    task automatic test_reset();
        wr(1, mk(2'b11, 30'h111));
        pulse_rc(1);
        pulse_rc(1);
        pulse_va(1);
        for (int k = 0; k < 5; k++) wr(0, mk(2'b01, 30'(k)));
        rd(1);
        nchecks++; if (bus.out_valid !== 1'b1) begin nerrors++; $display("FAIL reset_pre_valid: got %b expected 1", bus.out_valid); end
        nchecks++; if (bus.overflow_err !== 1'b1) begin nerrors++; $display("FAIL reset_pre_ovf: got %b expected 1", bus.overflow_err); end
        reset = 1'b0;
        #1;
        nchecks++; if (bus.out_valid !== 1'b0) begin nerrors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        nchecks++; if (bus.out_flit !== '0) begin nerrors++; $display("FAIL reset_out_flit: got %h expected 0", bus.out_flit); end
        nchecks++; if (bus.credit_valid !== 1'b0) begin nerrors++; $display("FAIL reset_credit_valid: got %b expected 0", bus.credit_valid); end
        nchecks++; if (bus.credit_vc !== 2'd0) begin nerrors++; $display("FAIL reset_credit_vc: got %0d expected 0", bus.credit_vc); end
        nchecks++; if (bus.vc_state !== 8'h00) begin nerrors++; $display("FAIL reset_vc_state: got %h expected 00", bus.vc_state); end
        nchecks++; if (bus.vc_empty !== 4'b1111) begin nerrors++; $display("FAIL reset_vc_empty: got %b expected 1111", bus.vc_empty); end
        nchecks++; if (bus.overflow_err !== 1'b0) begin nerrors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow_err); end
        model_reset();
        release_reset();
        nchecks++; if (bus.vc_empty !== 4'b1111) begin nerrors++; $display("FAIL reset_after_empty: got %b expected 1111", bus.vc_empty); end
    endtask

    task automatic test_single_packet();
        logic [FW-1:0] pkt [3];
        pkt[0] = mk(2'b00, 30'h0aa0);
        pkt[1] = mk(2'b01, 30'h0bb1);
        pkt[2] = mk(2'b10, 30'h0cc2);
        wr(2, pkt[0]);
        nchecks++; if (bus.vc_state[5:4] !== 2'b00) begin nerrors++; $display("FAIL sp_idle: got %b expected 00", bus.vc_state[5:4]); end
        wr(2, pkt[1]);
        wr(2, pkt[2]);
        nchecks++; if (bus.vc_state[5:4] !== 2'b01) begin nerrors++; $display("FAIL sp_routing: got %b expected 01", bus.vc_state[5:4]); end
        nchecks++; if (bus.head_flit[2*FW +: FW] !== pkt[0]) begin nerrors++; $display("FAIL sp_head_flit: got %h expected %h", bus.head_flit[2*FW +: FW], pkt[0]); end
        nchecks++; if (bus.vc_empty !== 4'b1011) begin nerrors++; $display("FAIL sp_empty: got %b expected 1011", bus.vc_empty); end
        pulse_rc(2);
        nchecks++; if (bus.vc_state[5:4] !== 2'b10) begin nerrors++; $display("FAIL sp_vc_alloc: got %b expected 10", bus.vc_state[5:4]); end
        pulse_va(2);
        nchecks++; if (bus.vc_state[5:4] !== 2'b11) begin nerrors++; $display("FAIL sp_active: got %b expected 11", bus.vc_state[5:4]); end
        for (int k = 0; k < 3; k++) begin
            rd(2);
            nchecks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== pkt[k]) begin nerrors++; $display("FAIL sp_read%0d: got v=%b %h expected v=1 %h", k, bus.out_valid, bus.out_flit, pkt[k]); end
            nchecks++; if (bus.credit_valid !== 1'b1 || bus.credit_vc !== 2'd2) begin nerrors++; $display("FAIL sp_credit%0d: got v=%b vc=%0d expected v=1 vc=2", k, bus.credit_valid, bus.credit_vc); end
        end
        nchecks++; if (bus.vc_state !== 8'h00) begin nerrors++; $display("FAIL sp_back_idle: got %h expected 00", bus.vc_state); end
        cyc(1'b0, 0, '0, '0, '0, 1'b0, 0);
        nchecks++; if (bus.out_valid !== 1'b0 || bus.credit_valid !== 1'b0) begin nerrors++; $display("FAIL sp_pulse: got v=%b c=%b expected 0 0", bus.out_valid, bus.credit_valid); end
        nchecks++; if (bus.vc_empty !== 4'b1111) begin nerrors++; $display("FAIL sp_drained: got %b expected 1111", bus.vc_empty); end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] f [5];
        f[0] = mk(2'b00, 30'h100);
        for (int k = 1; k < 5; k++) f[k] = mk(2'b01, 30'(32'h100 + k));
        for (int k = 0; k < 5; k++) begin
            wr(0, f[k]);
            if (k == 3) begin
                nchecks++; if (bus.overflow_err !== 1'b0) begin nerrors++; $display("FAIL ovf_early: got %b expected 0", bus.overflow_err); end
            end
        end
        nchecks++; if (bus.overflow_err !== 1'b1) begin nerrors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow_err); end
        pulse_rc(0);
        pulse_va(0);
        for (int k = 0; k < 5; k++) begin
            rd(0);
            if (k < 4) begin
                nchecks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== f[k]) begin nerrors++; $display("FAIL ovf_read%0d: got v=%b %h expected v=1 %h", k, bus.out_valid, bus.out_flit, f[k]); end
            end else begin
                nchecks++; if (bus.out_valid !== 1'b0 || bus.credit_valid !== 1'b0) begin nerrors++; $display("FAIL ovf_dropped: got v=%b c=%b expected 0 0", bus.out_valid, bus.credit_valid); end
            end
        end
        nchecks++; if (bus.overflow_err !== 1'b1) begin nerrors++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow_err); end
        apply_reset();
    endtask

    task automatic test_simul_rw();
        logic [FW-1:0] s [8];
        s[0] = mk(2'b00, 30'h200);
        s[1] = mk(2'b01, 30'h201);
        for (int k = 2; k < 7; k++) s[k] = mk(2'b01, 30'(32'h200 + k));
        s[7] = mk(2'b10, 30'h207);
        wr(1, s[0]);
        wr(1, s[1]);
        pulse_rc(1);
        pulse_va(1);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1, s[k+2], '0, '0, 1'b1, 1);
            nchecks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== s[k]) begin nerrors++; $display("FAIL rw_out%0d: got v=%b %h expected v=1 %h", k, bus.out_valid, bus.out_flit, s[k]); end
            nchecks++; if (bus.head_flit[FW +: FW] !== s[k+1] || bus.vc_empty[1] !== 1'b0) begin nerrors++; $display("FAIL rw_front%0d: got %h e=%b expected %h e=0", k, bus.head_flit[FW +: FW], bus.vc_empty[1], s[k+1]); end
        end
        for (int k = 6; k < 9; k++) begin
            rd(1);
            if (k < 8) begin
                nchecks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== s[k]) begin nerrors++; $display("FAIL rw_drain%0d: got v=%b %h expected v=1 %h", k, bus.out_valid, bus.out_flit, s[k]); end
            end else begin
                nchecks++; if (bus.out_valid !== 1'b0) begin nerrors++; $display("FAIL rw_count: got v=%b expected 0", bus.out_valid); end
            end
        end
        nchecks++; if (bus.vc_state[3:2] !== 2'b00 || bus.vc_empty[1] !== 1'b1) begin nerrors++; $display("FAIL rw_end: got st=%b e=%b expected 00 1", bus.vc_state[3:2], bus.vc_empty[1]); end
    endtask

    task automatic test_illegal_read();
        logic [FW-1:0] h2;
        h2 = mk(2'b00, 30'h321);
        wr(0, mk(2'b00, 30'h300));
        pulse_rc(0);
        pulse_rc(0);
        pulse_va(0);
        rd(0);
        rd(0);
        nchecks++; if (bus.out_valid !== 1'b0 || bus.credit_valid !== 1'b0) begin nerrors++; $display("FAIL ill_empty: got v=%b c=%b expected 0 0", bus.out_valid, bus.credit_valid); end
        nchecks++; if (bus.vc_state[1:0] !== 2'b11) begin nerrors++; $display("FAIL ill_empty_state: got %b expected 11", bus.vc_state[1:0]); end
        wr(2, h2);
        cyc(1'b0, 0, '0, 4'b0001, '0, 1'b0, 0);
        rd(2);
        nchecks++; if (bus.out_valid !== 1'b0 || bus.credit_valid !== 1'b0) begin nerrors++; $display("FAIL ill_routing: got v=%b c=%b expected 0 0", bus.out_valid, bus.credit_valid); end
        pulse_va(2);
        nchecks++; if (bus.vc_state !== 8'h13) begin nerrors++; $display("FAIL ill_states: got %h expected 13", bus.vc_state); end
        nchecks++; if (bus.head_flit[2*FW +: FW] !== h2 || bus.vc_empty !== 4'b1011) begin nerrors++; $display("FAIL ill_kept: got %h e=%b expected %h e=1011", bus.head_flit[2*FW +: FW], bus.vc_empty, h2); end
        apply_reset();
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] p [2];
        p[0] = mk(2'b11, 30'h3a);
        p[1] = mk(2'b11, 30'h3b);
        wr(3, p[0]);
        wr(3, p[1]);
        for (int k = 0; k < 2; k++) begin
            nchecks++; if (bus.vc_state !== 8'h40) begin nerrors++; $display("FAIL b2b_routing%0d: got %h expected 40", k, bus.vc_state); end
            pulse_rc(3);
            pulse_va(3);
            nchecks++; if (bus.vc_state !== 8'hc0) begin nerrors++; $display("FAIL b2b_active%0d: got %h expected c0", k, bus.vc_state); end
            rd(3);
            nchecks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== p[k]) begin nerrors++; $display("FAIL b2b_flit%0d: got v=%b %h expected v=1 %h", k, bus.out_valid, bus.out_flit, p[k]); end
            nchecks++; if (bus.credit_valid !== 1'b1 || bus.credit_vc !== 2'd3) begin nerrors++; $display("FAIL b2b_credit%0d: got v=%b vc=%0d expected v=1 vc=3", k, bus.credit_valid, bus.credit_vc); end
            nchecks++; if (bus.vc_state !== 8'h00) begin nerrors++; $display("FAIL b2b_idle%0d: got %h expected 00", k, bus.vc_state); end
            cyc(1'b0, 0, '0, '0, '0, 1'b0, 0);
        end
        nchecks++; if (bus.vc_state !== 8'h00 || bus.vc_empty !== 4'b1111) begin nerrors++; $display("FAIL b2b_end: got st=%h e=%b expected 00 1111", bus.vc_state, bus.vc_empty); end
    endtask

    task automatic test_random();
        logic [1:0]    t;
        logic [FW-1:0] hf;
        for (int n = 0; n < 1500; n++) begin
            if (n % 300 == 0) apply_reset();
            t = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) t = 2'b00;
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3), {t, 30'($urandom)},
                4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
            nchecks++; if (bus.out_valid !== exp_ov) begin nerrors++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", n, bus.out_valid, exp_ov); end
            nchecks++; if (bus.credit_valid !== exp_cv) begin nerrors++; $display("FAIL rnd_credit_valid@%0d: got %b expected %b", n, bus.credit_valid, exp_cv); end
            if (exp_ov) begin
                nchecks++; if (bus.out_flit !== exp_of) begin nerrors++; $display("FAIL rnd_out_flit@%0d: got %h expected %h", n, bus.out_flit, exp_of); end
                nchecks++; if (bus.credit_vc !== 2'(exp_cvc)) begin nerrors++; $display("FAIL rnd_credit_vc@%0d: got %0d expected %0d", n, bus.credit_vc, exp_cvc); end
            end
            nchecks++; if (bus.vc_state !== exp_states()) begin nerrors++; $display("FAIL rnd_vc_state@%0d: got %h expected %h", n, bus.vc_state, exp_states()); end
            nchecks++; if (bus.vc_empty !== exp_empty()) begin nerrors++; $display("FAIL rnd_vc_empty@%0d: got %b expected %b", n, bus.vc_empty, exp_empty()); end
            nchecks++; if (bus.overflow_err !== movf) begin nerrors++; $display("FAIL rnd_overflow@%0d: got %b expected %b", n, bus.overflow_err, movf); end
            for (int v = 0; v < NV; v++) begin
                if (mq[v].size() > 0) begin
                    hf = mq[v][0];
                    nchecks++; if (bus.head_flit[v*FW +: FW] !== hf) begin nerrors++; $display("FAIL rnd_head%0d@%0d: got %h expected %h", v, n, bus.head_flit[v*FW +: FW], hf); end
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #2;
        release_reset();
        test_reset();
        test_single_packet();
        test_overflow();
        test_simul_rw();
        test_illegal_read();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
